matvec_job_sequencer: RTL

Job-level front end for the 2x3 by 3x1 FP32 matrix-vector unit. It accepts a complete job (2x3 matrix A and 3x1 vector B) in one parallel transfer and streams the 9 words serially to the unit using its data_valid/data_done handshake. It then captures the two result words from the unit's calc_done burst, releases the unit with read_done, and presents {y1,y0} on a valid/ready output.
It sits directly upstream and downstream of the matrix unit, between the transform-setup logic and the rasteriser setup.

---
 rtl/matvec_pkg.sv | 30 +++
 rtl/matvec_job_sequencer.sv | 139 +++++++++++++
 2 files changed

// File: rtl/matvec_pkg.sv
// Shared types and constants for the matrix-vector job sequencer.
package matvec_pkg;

    localparam int N_A_WORDS = 6;
    localparam int N_B_WORDS = 3;
    localparam int N_WORDS   = 9;
    localparam int WORD_W    = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_RDY,
        ST_SEND,
        ST_WAIT_CALC,
        ST_CAP1,
        ST_RELEASE,
        ST_OUT
    } mv_seq_state_t;

    // FP32 encodings of small integers, handy for directed jobs
    localparam logic [31:0] FP32_ZERO    = 32'h0000_0000;
    localparam logic [31:0] FP32_ONE     = 32'h3F80_0000;
    localparam logic [31:0] FP32_TWO     = 32'h4000_0000;
    localparam logic [31:0] FP32_THREE   = 32'h4040_0000;
    localparam logic [31:0] FP32_FOUR    = 32'h4080_0000;
    localparam logic [31:0] FP32_FIVE    = 32'h40A0_0000;
    localparam logic [31:0] FP32_SIX     = 32'h40C0_0000;
    localparam logic [31:0] FP32_EIGHT   = 32'h4100_0000;
    localparam logic [31:0] FP32_FIFTEEN = 32'h4170_0000;

endpackage

// File: rtl/matvec_job_sequencer.sv
// Job front end for the 2x3 by 3x1 FP32 matrix-vector unit: streams A then B
// word-serially into the unit and returns {y1,y0} on a valid/ready port.
module matvec_job_sequencer
    import matvec_pkg::*;
#(
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                          iClk,
    input  logic                          iRst,
    input  logic                          job_valid,
    output logic                          job_ready,
    input  logic [N_A_WORDS*WORD_W-1:0]   job_a,
    input  logic [N_B_WORDS*WORD_W-1:0]   job_b,
    input  logic                          mv_ready,
    output logic                          mv_data_valid,
    output logic [WORD_W-1:0]             mv_data,
    input  logic                          mv_data_done,
    input  logic                          mv_calc_done,
    input  logic [WORD_W-1:0]             mv_result,
    output logic                          mv_read_done,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [2*WORD_W-1:0]           res_y,
    output logic                          busy,
    output logic                          err_timeout
);

    // state        | meaning
    // ST_IDLE      | accepting a job
    // ST_WAIT_RDY  | job buffered, unit not yet idle
    // ST_SEND      | streaming the 9 job words
    // ST_WAIT_CALC | waiting for the first result word (y0)
    // ST_CAP1      | capturing the second result word (y1)
    // ST_RELEASE   | read_done pulse to the unit
    // ST_OUT       | result held on res_y until consumed

    localparam int  WD_W  = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam int  IDX_W = $clog2(N_WORDS);
    localparam bit  WD_EN = (TIMEOUT_CYC != 0);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT_CYC);

    mv_seq_state_t        r_state;
    mv_seq_state_t        w_next;
    logic [WORD_W-1:0]    r_buf [N_WORDS];
    logic [WORD_W-1:0]    w_job_word [N_WORDS];
    logic [IDX_W-1:0]     r_word_idx;
    logic [WD_W-1:0]      r_wd_cnt;
    logic                 r_err;
    logic                 r_mv_valid;
    logic [WORD_W-1:0]    r_mv_data;
    logic [2*WORD_W-1:0]  r_res_y;
    logic                 w_job_hs;
    logic                 w_last_word;
    logic                 w_wd_run;

    for (genvar g = 0; g < N_A_WORDS; g++) begin : g_a_words
        assign w_job_word[g] = job_a[g*WORD_W +: WORD_W];
    end
    for (genvar g = 0; g < N_B_WORDS; g++) begin : g_b_words
        assign w_job_word[N_A_WORDS+g] = job_b[g*WORD_W +: WORD_W];
    end

    assign w_job_hs    = job_valid && (r_state == ST_IDLE);
    assign w_last_word = (r_word_idx == IDX_W'(N_WORDS - 1));
    assign w_wd_run    = (r_state == ST_WAIT_RDY) || (r_state == ST_SEND) ||
                         (r_state == ST_WAIT_CALC);

    // An idle unit at handshake time lets the first word go out on the next cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:      if (job_valid) w_next = mv_ready ? ST_SEND : ST_WAIT_RDY;
            ST_WAIT_RDY:  if (mv_ready) w_next = ST_SEND;
            ST_SEND:      if (mv_data_done && w_last_word) w_next = ST_WAIT_CALC;
            ST_WAIT_CALC: if (mv_calc_done) w_next = ST_CAP1;
            ST_CAP1:      w_next = ST_RELEASE;
            ST_RELEASE:   w_next = ST_OUT;
            ST_OUT:       if (res_ready) w_next = ST_IDLE;
            default:      w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state    <= ST_IDLE;
            r_buf      <= '{default: '0};
            r_word_idx <= '0;
            r_wd_cnt   <= '0;
            r_err      <= 1'b0;
            r_mv_valid <= 1'b0;
            r_mv_data  <= '0;
            r_res_y    <= '0;
        end else begin
            r_state <= w_next;

            if (r_state != w_next)
                r_wd_cnt <= '0;
            else if (WD_EN && w_wd_run && r_wd_cnt != WD_MAX)
                r_wd_cnt <= r_wd_cnt + WD_W'(1);

            if (WD_EN && w_wd_run && (r_state == w_next) && (r_wd_cnt == WD_LAST))
                r_err <= 1'b1;
            if ((r_state == ST_CAP1) && !mv_calc_done)
                r_err <= 1'b1;

            if (w_job_hs)
                r_buf <= w_job_word;

            if ((w_next == ST_SEND) && (r_state != ST_SEND)) begin
                r_mv_valid <= 1'b1;
                r_word_idx <= '0;
                r_mv_data  <= (r_state == ST_IDLE) ? w_job_word[0] : r_buf[0];
            end else if ((r_state == ST_SEND) && mv_data_done) begin
                if (w_last_word) begin
                    r_mv_valid <= 1'b0;
                end else begin
                    r_word_idx <= r_word_idx + IDX_W'(1);
                    r_mv_data  <= r_buf[r_word_idx + IDX_W'(1)];
                end
            end

            if ((r_state == ST_WAIT_CALC) && mv_calc_done)
                r_res_y[WORD_W-1:0] <= mv_result;
            if (r_state == ST_CAP1)
                r_res_y[2*WORD_W-1:WORD_W] <= mv_result;
        end
    end

    assign job_ready     = (r_state == ST_IDLE);
    assign busy          = (r_state != ST_IDLE);
    assign mv_data_valid = r_mv_valid;
    assign mv_data       = r_mv_data;
    assign mv_read_done  = (r_state == ST_RELEASE);
    assign res_valid     = (r_state == ST_OUT);
    assign res_y         = r_res_y;
    assign err_timeout   = r_err;

endmodule
